// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: walks the i/j/k loop nest of dst = lhs x rhs^T and issues one MAC operand pair per step.
// Define GEMM_SEQ_PERF_EN to return the RUN+DRAIN cycle count instead of the element count.
module gemm_seq_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic        nice_clk,
  input  logic        nice_rst_n,
  input  logic        start,
  input  logic [31:0] lhs_cols,
  input  logic [31:0] lhs_rows,
  input  logic [31:0] rhs_cols,
  input  logic [31:0] lhs_addr,
  input  logic [31:0] rhs_addr,
  input  logic [31:0] dst_addr,
  output logic [1:0]  state,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_lhs_addr,
  output logic [31:0] op_rhs_addr,
  output logic        op_first,
  output logic        op_last,
  output logic [31:0] op_dst_addr,
  input  logic        wb_done,
  output logic        nice_rsp_multicyc_valid,
  input  logic        nice_rsp_multicyc_ready,
  output logic [31:0] nice_rsp_multicyc_dat,
  output logic        nice_rsp_multicyc_err
);
  localparam int OW = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, RESP = 2'b11} state_t;
  state_t r_state, w_nxt;
  logic [CNT_W-1:0] r_k, r_m, r_n, r_kc, r_i, r_j;
  logic [31:0] r_lhs_row, r_lhs, r_rhs_base, r_rhs_row, r_rhs, r_dst;
  logic [OW-1:0] r_out;
  logic r_err;
  logic w_launch, w_bad, w_acc, w_k_end, w_j_end, w_final, w_wb_live, w_inc, w_dec;
  logic [31:0] w_k32;
  assign w_launch  = r_state == IDLE && start;
  assign w_bad     = ~|lhs_cols | ~|lhs_rows | ~|rhs_cols |
                     |(lhs_cols >> CNT_W) | |(lhs_rows >> CNT_W) | |(rhs_cols >> CNT_W);
  assign w_k_end   = r_kc == r_k - CNT_W'(1);
  assign w_j_end   = r_j == r_n - CNT_W'(1);
  assign w_final   = w_k_end && w_j_end && r_i == r_m - CNT_W'(1);
  assign w_k32     = 32'(r_k);
  assign op_first  = r_state == RUN && r_kc == '0;
  assign op_last   = r_state == RUN && w_k_end;
  // A new dst element may only start while a write-back slot is free.
  assign op_valid  = r_state == RUN && !(r_kc == '0 && r_out == OW'(MAX_OUT));
  assign w_acc     = op_valid && op_ready;
  assign w_inc     = w_acc && w_k_end;
  assign w_wb_live = wb_done && (r_state == RUN || r_state == DRAIN);
  assign w_dec     = w_wb_live && r_out != '0;
  assign state                   = r_state;
  assign op_lhs_addr             = r_lhs;
  assign op_rhs_addr             = r_rhs;
  assign op_dst_addr             = r_dst;
  assign nice_rsp_multicyc_valid = r_state == RESP;
  assign nice_rsp_multicyc_err   = r_err;
  always_ff @(posedge nice_clk or negedge nice_rst_n)
    if (!nice_rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = start ? (w_bad ? RESP : RUN) : IDLE;
      RUN:     w_nxt = w_acc && w_final ? DRAIN : RUN;
      DRAIN:   w_nxt = r_out == '0 ? RESP : DRAIN;
      default: w_nxt = nice_rsp_multicyc_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge nice_clk or negedge nice_rst_n)
    if (!nice_rst_n) begin
      r_k <= '0;
      r_m <= '0;
      r_n <= '0;
      r_kc <= '0;
      r_i <= '0;
      r_j <= '0;
      r_lhs_row <= '0;
      r_lhs <= '0;
      r_rhs_base <= '0;
      r_rhs_row <= '0;
      r_rhs <= '0;
      r_dst <= '0;
    end else if (w_launch) begin
      r_k <= lhs_cols[CNT_W-1:0];
      r_m <= lhs_rows[CNT_W-1:0];
      r_n <= rhs_cols[CNT_W-1:0];
      r_kc <= '0;
      r_i <= '0;
      r_j <= '0;
      r_lhs_row <= lhs_addr;
      r_lhs <= lhs_addr;
      r_rhs_base <= rhs_addr;
      r_rhs_row <= rhs_addr;
      r_rhs <= rhs_addr;
      r_dst <= dst_addr;
    end else if (w_acc) begin
      if (!w_k_end) begin
        r_kc <= r_kc + CNT_W'(1);
        r_lhs <= r_lhs + 32'd1;
        r_rhs <= r_rhs + 32'd1;
      end else begin
        r_kc <= '0;
        r_dst <= r_dst + 32'd1;
        if (!w_j_end) begin
          r_j <= r_j + CNT_W'(1);
          r_lhs <= r_lhs_row;
          r_rhs_row <= r_rhs_row + w_k32;
          r_rhs <= r_rhs_row + w_k32;
        end else begin
          r_j <= '0;
          r_i <= r_i + CNT_W'(1);
          r_lhs_row <= r_lhs_row + w_k32;
          r_lhs <= r_lhs_row + w_k32;
          r_rhs_row <= r_rhs_base;
          r_rhs <= r_rhs_base;
        end
      end
    end
  // A write-back with nothing outstanding is dropped but flagged.
  always_ff @(posedge nice_clk or negedge nice_rst_n)
    if (!nice_rst_n) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else if (w_launch) begin
      r_out <= '0;
      r_err <= w_bad;
    end else begin
      r_out <= r_out + OW'(w_inc) - OW'(w_dec);
      if (w_wb_live && r_out == '0) r_err <= 1'b1;
    end
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] r_cyc;
  always_ff @(posedge nice_clk or negedge nice_rst_n)
    if (!nice_rst_n) r_cyc <= '0;
    else if (w_launch) r_cyc <= '0;
    else if ((r_state == RUN || r_state == DRAIN) && r_cyc != '1) r_cyc <= r_cyc + 32'd1;
  assign nice_rsp_multicyc_dat = r_cyc;
`else
  logic [31:0] r_elem;
  always_ff @(posedge nice_clk or negedge nice_rst_n)
    if (!nice_rst_n) r_elem <= '0;
    else if (w_launch) r_elem <= '0;
    else if (w_dec) r_elem <= r_elem + 32'd1;
  assign nice_rsp_multicyc_dat = r_elem;
`endif
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// tb_gemm_seq_ctrl: randomized self-checking bench for gemm_seq_ctrl against a loop-nest reference model.
module tb_gemm_seq_ctrl;
  localparam int MAX_OUT = 4;
  logic nice_clk = 1'b0, nice_rst_n = 1'b0, start = 1'b0, op_ready = 1'b0, wb_done = 1'b0, rsp_ready = 1'b0;
  logic [31:0] lhs_cols = '0, lhs_rows = '0, rhs_cols = '0, lhs_addr = '0, rhs_addr = '0, dst_addr = '0;
  logic [1:0] state;
  logic op_valid, op_first, op_last, rsp_valid, rsp_err;
  logic [31:0] op_lhs_addr, op_rhs_addr, op_dst_addr, rsp_dat;
  gemm_seq_ctrl #(.CNT_W(16), .MAX_OUT(MAX_OUT)) dut (
    .nice_clk(nice_clk), .nice_rst_n(nice_rst_n), .start(start),
    .lhs_cols(lhs_cols), .lhs_rows(lhs_rows), .rhs_cols(rhs_cols),
    .lhs_addr(lhs_addr), .rhs_addr(rhs_addr), .dst_addr(dst_addr),
    .state(state), .op_valid(op_valid), .op_ready(op_ready),
    .op_lhs_addr(op_lhs_addr), .op_rhs_addr(op_rhs_addr),
    .op_first(op_first), .op_last(op_last), .op_dst_addr(op_dst_addr),
    .wb_done(wb_done), .nice_rsp_multicyc_valid(rsp_valid),
    .nice_rsp_multicyc_ready(rsp_ready), .nice_rsp_multicyc_dat(rsp_dat),
    .nice_rsp_multicyc_err(rsp_err)
  );
  always #5 nice_clk = ~nice_clk;
  typedef struct {logic [31:0] lhs, rhs, dst; logic first, last;} op_t;
  op_t q[$];
  int unsigned wbq[$];
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic reset_check();
    nice_rst_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_first", op_first, 0);
    check("rst_op_last", op_last, 0);
    check("rst_op_lhs", op_lhs_addr, 0);
    check("rst_op_rhs", op_rhs_addr, 0);
    check("rst_op_dst", op_dst_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge nice_clk);
    nice_rst_n = 1'b1;
  endtask
  task automatic run(input int unsigned m, k, n, input logic [31:0] la, ra, da,
                     input int pct, dmin, dmax, stall_op, rsp_hold, input bit spur, input int abort_at);
    int phase, nxt, out, acc, stalls, held;
    int unsigned t, elems, cyc, exp_dat;
    bit bad, err, ev, accept, inc, done;
    bad = m == 0 || k == 0 || n == 0 || m > 65535 || k > 65535 || n > 65535;
    q.delete();
    wbq.delete();
    if (!bad)
      for (int unsigned i = 0; i < m; i++)
        for (int unsigned j = 0; j < n; j++)
          for (int unsigned kk = 0; kk < k; kk++)
            q.push_back('{la + i * k + kk, ra + j * k + kk, da + i * n + j, kk == 0, kk == k - 1});
    @(negedge nice_clk);
    lhs_rows = m; lhs_cols = k; rhs_cols = n;
    lhs_addr = la; rhs_addr = ra; dst_addr = da;
    start = 1'b1;
    phase = bad ? 3 : 1;
    err = bad; out = 0; elems = 0; cyc = 0; acc = 0; t = 0; stalls = 0; held = 0; done = 0;
    while (t < 1500) begin
      @(negedge nice_clk);
      t++;
      start = $urandom_range(7) == 0;
      lhs_rows = $urandom; lhs_cols = $urandom; rhs_cols = $urandom;
      lhs_addr = $urandom; rhs_addr = $urandom; dst_addr = $urandom;
      check("state", state, phase);
      ev = phase == 1 && !(q[0].first && out == MAX_OUT);
      check("op_valid", op_valid, ev);
      if (ev) begin
        check("op_lhs", op_lhs_addr, q[0].lhs);
        check("op_rhs", op_rhs_addr, q[0].rhs);
        check("op_first", op_first, q[0].first);
        check("op_last", op_last, q[0].last);
        if (q[0].last) check("op_dst", op_dst_addr, q[0].dst);
      end
      check("rsp_valid", rsp_valid, phase == 3);
`ifdef GEMM_SEQ_PERF_EN
      exp_dat = cyc;
`else
      exp_dat = elems;
`endif
      if (phase == 3) begin
        check("rsp_dat", rsp_dat, exp_dat);
        check("rsp_err", rsp_err, err);
      end
      op_ready = $urandom_range(99) < pct;
      if (ev && acc == stall_op && stalls < 3) begin
        op_ready = 1'b0;
        stalls++;
      end
      wb_done = 1'b0;
      if (wbq.size() > 0 && wbq[0] <= t) begin
        wb_done = 1'b1;
        void'(wbq.pop_front());
      end
      if (spur && phase == 2 && out == 0) begin
        wb_done = 1'b1;
        spur = 0;
      end
      rsp_ready = $urandom_range(1);
      if (phase == 3) begin
        rsp_ready = held >= rsp_hold;
        if (held < rsp_hold) held++;
      end
      nxt = phase;
      if (phase == 1 || phase == 2) cyc++;
      if (phase == 2 && out == 0) nxt = 3;
      if (phase == 3 && rsp_ready) nxt = 0;
      accept = ev && op_ready;
      inc = accept && q[0].last;
      if (accept) begin
        if (q[0].last) wbq.push_back(t + $urandom_range(dmax, dmin));
        void'(q.pop_front());
        acc++;
        if (q.size() == 0) nxt = 2;
      end
      if (wb_done && (phase == 1 || phase == 2)) begin
        if (out == 0) err = 1;
        else begin
          out--;
          elems++;
        end
      end
      if (inc) out++;
      phase = nxt;
      if (phase == 0 || (abort_at >= 0 && acc == abort_at)) begin
        done = 1;
        break;
      end
    end
    check("run_in_budget", done, 1);
    start = 1'b0;
    wb_done = 1'b0;
    op_ready = 1'b0;
    if (abort_at >= 0) begin
      @(negedge nice_clk);
      reset_check();
    end else begin
      @(negedge nice_clk);
      check("idle_state", state, 0);
      check("idle_rsp_valid", rsp_valid, 0);
    end
  endtask
  initial begin
    @(negedge nice_clk);
    reset_check();
    run(2, 3, 2, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, -1, 0, 0, -1);
    run(2, 3, 0, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, -1, 0, 0, -1);
    run(2, 65536, 2, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, -1, 0, 0, -1);
    run(2, 3, 2, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, 5, 0, 0, -1);
    run(1, 1, 8, 32'h1000, 32'h2000, 32'h3000, 100, 12, 12, -1, 0, 0, -1);
    run(2, 3, 2, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, -1, 5, 1, -1);
    run(2, 3, 2, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, -1, 0, 0, 8);
    run(2, 3, 2, 32'h1000, 32'h2000, 32'h3000, 100, 2, 2, -1, 0, 0, -1);
    run(3, 2, 3, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 100, 1, 3, -1, 0, 0, -1);
    for (int r = 0; r < 20; r++)
      run($urandom_range(4, 1), $urandom_range(4, 1), $urandom_range(4, 1),
          $urandom_range(1) ? $urandom : 32'hFFFF_FFF8, $urandom, $urandom,
          $urandom_range(100, 50), 0, $urandom_range(8), $urandom_range(10) - 1,
          $urandom_range(3), $urandom_range(1), -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
